// File: rtl/demux_1x4_buf.sv
// -----------------------------------------------------------------------------
// demux_1x4_buf
//
// Registered 1-to-4 demultiplexer with a one-entry holding buffer per channel.
// A single producer stream (in_valid/in_ready, s, d) is steered to channel s.
// Each channel presents its own valid/ready handshake, so a stalled consumer
// blocks only the producer words aimed at its own channel.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   producer has a word on d for channel s
//   in_ready   block accepts the current word (combinational from s/out_ready)
//   s          destination channel (0..3), sampled with d
//   d          input data word
//   out_valid  bit k: channel k buffer holds a word
//   out_ready  bit k: consumer k takes the word this cycle
//   o          channel data, channel k at bits [k*W +: W]
//   cnt        accepted-word counter, wraps modulo 256
// -----------------------------------------------------------------------------
module demux_1x4_buf #(
  parameter int unsigned W = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [1:0]     s,
  input  logic [W-1:0]   d,
  output logic [3:0]     out_valid,
  input  logic [3:0]     out_ready,
  output logic [4*W-1:0] o,
  output logic [7:0]     cnt
);

  logic [3:0]   r_full;
  logic [W-1:0] r_buf [4];
  logic [7:0]   r_cnt;

  logic         w_acc;
  logic [3:0]   w_load;
  logic [3:0]   w_drain;
  logic [3:0]   w_full_d;

  // Only the selected channel gates acceptance; a full channel still accepts
  // when its consumer drains on the same edge (pass-through refill).
  assign in_ready = ~r_full[s] | out_ready[s];
  assign w_acc    = in_valid & in_ready;
  assign w_drain  = r_full & out_ready;

  always_comb begin
    w_load    = '0;
    w_load[s] = w_acc;
  end

  // Load wins over a same-cycle drain of the same channel.
  always_comb begin
    w_full_d = r_full;
    for (int k = 0; k < 4; k++) begin
      if (w_load[k]) begin
        w_full_d[k] = 1'b1;
      end else if (w_drain[k]) begin
        w_full_d[k] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_full <= '0;
    end else begin
      r_full <= w_full_d;
    end
  end

  // Buffer contents are held after a drain; only a load overwrites them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < 4; k++) begin
        r_buf[k] <= '0;
      end
    end else begin
      for (int k = 0; k < 4; k++) begin
        if (w_load[k]) begin
          r_buf[k] <= d;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (w_acc) begin
      r_cnt <= r_cnt + 8'd1;
    end
  end

  assign out_valid = r_full;
  assign cnt       = r_cnt;

  always_comb begin
    o = '0;
    for (int k = 0; k < 4; k++) begin
      o[k*W +: W] = r_buf[k];
    end
  end

endmodule

// File: tb/tb_demux_1x4_buf.sv
module tb_demux_1x4_buf;

  localparam int unsigned W = 4;

  logic           clk;
  logic           rst_n;
  logic           in_valid;
  logic           in_ready;
  logic [1:0]     s;
  logic [W-1:0]   d;
  logic [3:0]     out_valid;
  logic [3:0]     out_ready;
  logic [4*W-1:0] o;
  logic [7:0]     cnt;

  int n_tests;
  int n_fail;

  // Reference state for the random scenarios
  logic [3:0]   m_full;
  logic [W-1:0] m_buf [4];
  logic [7:0]   m_cnt;
  int           n_acc;
  int           n_drain;

  demux_1x4_buf #(.W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .s         (s),
    .d         (d),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .o         (o),
    .cnt       (cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    s         = 2'd0;
    d         = '0;
    #2;
    rst_n     = 1'b1;
    #1;
    m_full  = '0;
    m_cnt   = '0;
    n_acc   = 0;
    n_drain = 0;
    for (int k = 0; k < 4; k++) m_buf[k] = '0;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 4'b0000;
    s         = 2'd0;
    d         = '0;
    #1;
    n_tests++;
    if (out_valid !== 4'b0000 || o !== 16'h0000 || cnt !== 8'd0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_initial: out_valid=%b o=%h cnt=%0d in_ready=%b, want 0000/0000/0/1",
               out_valid, o, cnt, in_ready);
    end
    #2;
    rst_n = 1'b1;
    tick();
    // fill channels 1 and 3 with stalled consumers
    in_valid = 1'b1; s = 2'd1; d = 4'h7;
    tick();
    s = 2'd3; d = 4'h9;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 4'b1010 || o !== 16'h9070) begin
      n_fail++;
      $display("FAIL reset_prefill: out_valid=%b o=%h, want 1010/9070", out_valid, o);
    end
    // assert reset between edges
    in_valid = 1'b1; s = 2'd1; d = 4'hE;
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (out_valid !== 4'b0000 || o !== 16'h0000 || cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL reset_midstream: out_valid=%b o=%h cnt=%0d, want 0000/0000/0",
               out_valid, o, cnt);
    end
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_in_ready: in_ready=%b, want 1", in_ready);
    end
    // an edge while reset is held completes no handshake
    tick();
    n_tests++;
    if (out_valid !== 4'b0000 || cnt !== 8'd0 || o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_hold_edge: out_valid=%b o=%h cnt=%0d, want 0000/0000/0",
               out_valid, o, cnt);
    end
    in_valid = 1'b0;
    rst_n    = 1'b1;
  endtask

  task automatic test_routing();
    logic [W-1:0] exp_d;
    logic [3:0]   exp_ov;
    do_reset();
    out_ready = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      exp_d    = W'(1 << i);
      exp_ov   = 4'(1 << i);
      in_valid = 1'b1;
      s        = 2'(i);
      d        = exp_d;
      #1;
      n_tests++;
      if (in_ready !== 1'b1) begin
        n_fail++;
        $display("FAIL routing_in_ready[%0d]: in_ready=%b, want 1", i, in_ready);
      end
      tick();
      n_tests++;
      if (out_valid !== exp_ov || o[i*W +: W] !== exp_d) begin
        n_fail++;
        $display("FAIL routing_ch%0d: out_valid=%b data=%h, want %b/%h",
                 i, out_valid, o[i*W +: W], exp_ov, exp_d);
      end
    end
    in_valid = 1'b0;
    n_tests++;
    if (cnt !== 8'd4) begin
      n_fail++;
      $display("FAIL routing_cnt: cnt=%0d, want 4", cnt);
    end
    tick();
    n_tests++;
    if (out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL routing_drained: out_valid=%b, want 0000", out_valid);
    end
  endtask

  task automatic test_stall();
    do_reset();
    out_ready = 4'b1101;
    in_valid = 1'b1; s = 2'd1; d = 4'hA;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_first_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    d = 4'hB;
    #1;
    n_tests++;
    if (in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL stall_blocked: in_ready=%b, want 0", in_ready);
    end
    for (int c = 0; c < 2; c++) begin
      tick();
      n_tests++;
      if (out_valid !== 4'b0010 || o[1*W +: W] !== 4'hA || in_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL stall_hold[%0d]: out_valid=%b ch1=%h in_ready=%b, want 0010/a/0",
                 c, out_valid, o[1*W +: W], in_ready);
      end
    end
    out_ready = 4'b1111;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL stall_release_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    n_tests++;
    if (out_valid !== 4'b0010 || o[1*W +: W] !== 4'hB) begin
      n_fail++;
      $display("FAIL stall_refill: out_valid=%b ch1=%h, want 0010/b", out_valid, o[1*W +: W]);
    end
    s = 2'd2; d = 4'hC;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 4'b0100 || o[2*W +: W] !== 4'hC || cnt !== 8'd3) begin
      n_fail++;
      $display("FAIL stall_final: out_valid=%b ch2=%h cnt=%0d, want 0100/c/3",
               out_valid, o[2*W +: W], cnt);
    end
  endtask

  task automatic test_pass_through();
    do_reset();
    in_valid = 1'b1; s = 2'd2; d = 4'h5;
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 4'b0100 || o[2*W +: W] !== 4'h5) begin
      n_fail++;
      $display("FAIL pass_load: out_valid=%b ch2=%h, want 0100/5", out_valid, o[2*W +: W]);
    end
    out_ready = 4'b0100;
    in_valid = 1'b1; s = 2'd2; d = 4'h6;
    #1;
    n_tests++;
    if (in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL pass_in_ready: in_ready=%b, want 1", in_ready);
    end
    tick();
    in_valid = 1'b0;
    n_tests++;
    if (out_valid !== 4'b0100 || o[2*W +: W] !== 4'h6 || cnt !== 8'd2) begin
      n_fail++;
      $display("FAIL pass_refill: out_valid=%b ch2=%h cnt=%0d, want 0100/6/2",
               out_valid, o[2*W +: W], cnt);
    end
    tick();
    n_tests++;
    if (out_valid !== 4'b0000 || o[2*W +: W] !== 4'h6) begin
      n_fail++;
      $display("FAIL pass_drain: out_valid=%b ch2=%h, want 0000/6 (held)",
               out_valid, o[2*W +: W]);
    end
  endtask

  // valid_mode: 0 = idle, 1 = always valid, 2 = random valid
  task automatic run_cycles(input int n, input int valid_mode, input bit all_ready);
    logic           exp_rdy;
    logic           acc;
    logic [3:0]     drain;
    logic [3:0]     stall;
    logic [4*W-1:0] o_prev;
    for (int c = 0; c < n; c++) begin
      in_valid  = (valid_mode == 1) ? 1'b1 :
                  (valid_mode == 2) ? 1'($urandom_range(0, 1)) : 1'b0;
      s         = 2'($urandom_range(0, 3));
      d         = W'($urandom);
      out_ready = all_ready ? 4'b1111 : 4'($urandom);
      #1;
      exp_rdy = ~m_full[s] | out_ready[s];
      n_tests++;
      if (in_ready !== exp_rdy) begin
        n_fail++;
        $display("FAIL rand_in_ready c=%0d: in_ready=%b, want %b", c, in_ready, exp_rdy);
      end
      n_tests++;
      if (out_valid !== m_full) begin
        n_fail++;
        $display("FAIL rand_out_valid c=%0d: out_valid=%b, want %b", c, out_valid, m_full);
      end
      drain = m_full & out_ready;
      for (int k = 0; k < 4; k++) begin
        if (drain[k]) begin
          n_drain++;
          n_tests++;
          if (o[k*W +: W] !== m_buf[k]) begin
            n_fail++;
            $display("FAIL rand_drain_data c=%0d ch%0d: data=%h, want %h",
                     c, k, o[k*W +: W], m_buf[k]);
          end
        end
      end
      acc    = in_valid & exp_rdy;
      stall  = m_full & ~out_ready;
      o_prev = o;
      tick();
      m_full = m_full & ~drain;
      if (acc) begin
        m_full[s] = 1'b1;
        m_buf[s]  = d;
        m_cnt     = m_cnt + 8'd1;
        n_acc++;
      end
      n_tests++;
      if (cnt !== m_cnt) begin
        n_fail++;
        $display("FAIL rand_cnt c=%0d: cnt=%0d, want %0d", c, cnt, m_cnt);
      end
      for (int k = 0; k < 4; k++) begin
        if (stall[k]) begin
          n_tests++;
          if (o[k*W +: W] !== o_prev[k*W +: W] || out_valid[k] !== 1'b1) begin
            n_fail++;
            $display("FAIL rand_stall_stable c=%0d ch%0d: data=%h valid=%b, want %h/1",
                     c, k, o[k*W +: W], out_valid[k], o_prev[k*W +: W]);
          end
        end
      end
    end
  endtask

  task automatic test_counter_wrap();
    do_reset();
    run_cycles(256, 1, 1'b1);
    n_tests++;
    if (cnt !== 8'd0) begin
      n_fail++;
      $display("FAIL wrap_cnt: cnt=%0d, want 0", cnt);
    end
    run_cycles(2, 0, 1'b1);
    n_tests++;
    if (n_acc != 256 || n_drain != 256 || out_valid !== 4'b0000) begin
      n_fail++;
      $display("FAIL wrap_delivery: accepted=%0d drained=%0d out_valid=%b, want 256/256/0000",
               n_acc, n_drain, out_valid);
    end
  endtask

  task automatic test_random_soak();
    do_reset();
    run_cycles(10000, 2, 1'b0);
    run_cycles(2, 0, 1'b1);
    n_tests++;
    if (n_drain != n_acc || out_valid !== 4'b0000 || cnt !== m_cnt) begin
      n_fail++;
      $display("FAIL soak_delivery: accepted=%0d drained=%0d out_valid=%b cnt=%0d, want %0d/%0d/0000/%0d",
               n_acc, n_drain, out_valid, cnt, n_acc, n_acc, m_cnt);
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    m_full  = '0;
    m_cnt   = '0;
    n_acc   = 0;
    n_drain = 0;
    test_reset();
    test_routing();
    test_stall();
    test_pass_through();
    test_counter_wrap();
    test_random_soak();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
